// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if
// Groups the pixel stream, the window taps and the core result path of the
// Sobel window controller.
//   pix_in/pix_valid/pix_ready : raster-order input stream with ready handshake
//   z1..z9 (no z5)             : 3x3 window taps driven to the Sobel core
//   core_z_out                 : registered Sobel core result fed back in
//   out_pix/out_valid          : gradient output stream (no backpressure)
// master = upstream/core side, slave = sobel_window_ctrl.
interface sobel_window_ctrl_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] z1, z2, z3, z4, z6, z7, z8, z9;
  logic [7:0] core_z_out;
  logic [7:0] out_pix;
  logic       out_valid;

  modport master (
    output pix_in, pix_valid, core_z_out,
    input  pix_ready, z1, z2, z3, z4, z6, z7, z8, z9, out_pix, out_valid
  );

  modport slave (
    input  pix_in, pix_valid, core_z_out,
    output pix_ready, z1, z2, z3, z4, z6, z7, z8, z9, out_pix, out_valid
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
// Builds a sliding 3x3 window over a raster-order frame using two line
// buffers, feeds the taps to an external one-register Sobel core and frames
// the core result into a valid-qualified output stream.
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   start      : frame-start request, honoured only in IDLE
//   bus        : pixel stream, window taps, core result and output stream
//   busy       : state is not IDLE
//   frame_done : one-cycle pulse coincident with the last out_valid
module sobel_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  sobel_window_ctrl_if.slave        bus,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             drain_reg;
  logic             win_valid_reg;
  logic             out_valid_reg;
  logic             frame_done_reg;
  logic [7:0]       z1_reg, z2_reg, z3_reg;
  logic [7:0]       z4_reg, z5_reg, z6_reg;
  logic [7:0]       z7_reg, z8_reg, z9_reg;

  // LB0 holds line r-1, LB1 holds line r-2
  logic [7:0]       lb0 [IMG_W];
  logic [7:0]       lb1 [IMG_W];
  logic [7:0]       lb0_rd_reg;
  logic [7:0]       lb1_rd_reg;

  logic             accept;
  logic             last_col;
  logic             last_row;
  logic [COL_W-1:0] col_next;
  logic [COL_W-1:0] rd_addr;

  assign accept   = bus.pix_valid && (state_reg == STREAM);
  assign last_col = (col_reg == COL_W'(IMG_W - 1));
  assign last_row = (row_reg == ROW_W'(IMG_H - 1));
  assign col_next = last_col ? '0 : col_reg + COL_W'(1);

  // The read port runs one column ahead so the registered read data is
  // already LBx[col] when the pixel for col arrives; during a stall it keeps
  // re-reading the current column. The write address (col) never equals the
  // read address on an accept because IMG_W >= 3.
  assign rd_addr = accept ? col_next : col_reg;

  always_ff @(posedge clk) begin
    lb0_rd_reg <= lb0[rd_addr];
    lb1_rd_reg <= lb1[rd_addr];
    if (accept) begin
      lb0[col_reg] <= bus.pix_in;
      lb1[col_reg] <= lb0_rd_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      drain_reg      <= 1'b0;
      win_valid_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      z1_reg <= '0; z2_reg <= '0; z3_reg <= '0;
      z4_reg <= '0; z5_reg <= '0; z6_reg <= '0;
      z7_reg <= '0; z8_reg <= '0; z9_reg <= '0;
    end else begin
      // out_valid trails win_valid by the core's single register stage
      out_valid_reg  <= win_valid_reg;
      // windows touching col<2 or row<2 straddle a border or a line wrap
      win_valid_reg  <= accept && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
      frame_done_reg <= 1'b0;

      if (accept) begin
        z1_reg <= z2_reg; z2_reg <= z3_reg; z3_reg <= lb1_rd_reg;
        z4_reg <= z5_reg; z5_reg <= z6_reg; z6_reg <= lb0_rd_reg;
        z7_reg <= z8_reg; z8_reg <= z9_reg; z9_reg <= bus.pix_in;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= STREAM;
            col_reg   <= '0;
            row_reg   <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            col_reg <= col_next;
            if (last_col) begin
              row_reg <= last_row ? '0 : row_reg + ROW_W'(1);
              if (last_row) begin
                state_reg <= DRAIN;
                drain_reg <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          // first cycle: let the final window reach out_valid and flag the end
          if (!drain_reg) begin
            drain_reg      <= 1'b1;
            frame_done_reg <= 1'b1;
          end else begin
            drain_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready = (state_reg == STREAM);
  assign bus.z1        = z1_reg;
  assign bus.z2        = z2_reg;
  assign bus.z3        = z3_reg;
  assign bus.z4        = z4_reg;
  assign bus.z6        = z6_reg;
  assign bus.z7        = z7_reg;
  assign bus.z8        = z8_reg;
  assign bus.z9        = z9_reg;
  assign bus.out_pix   = bus.core_z_out;
  assign bus.out_valid = out_valid_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = frame_done_reg;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl
// Three controller instances (4x4, 3x3, 5x4) each paired with a behavioural
// one-register Sobel core. Expected gradients are computed from the bench's
// own image array when a qualifying pixel is driven and popped on out_valid.
module tb_sobel_window_ctrl;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [NDUT];
  logic       start_s [NDUT];
  logic       valid_s [NDUT];
  logic [7:0] pix_s   [NDUT];
  logic       ready_o [NDUT];
  logic       outv_o  [NDUT];
  logic [7:0] outp_o  [NDUT];
  logic       busy_o  [NDUT];
  logic       fd_o    [NDUT];

  int         checks = 0;
  int         errors = 0;
  int         img [8][8];
  logic [7:0] exp_q [$];
  logic [7:0] cap_q [$];
  logic [7:0] ref_cap [$];
  int         out_cnt [NDUT];
  int         fd_cnt  [NDUT];
  logic       fd_prev [NDUT];
  logic [7:0] mon_exp;

  function automatic logic [7:0] sobel(input int a1, a2, a3, a4, a6, a7, a8, a9);
    int gx, gy;
    gx = (a3 + 2*a6 + a9) - (a1 + 2*a4 + a7);
    gy = (a7 + 2*a8 + a9) - (a1 + 2*a2 + a3);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return 8'((gx + gy) >> 3);
  endfunction

  function automatic logic [7:0] sobel_ref(input int r, input int c);
    return sobel(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                 img[r-1][c-2],                img[r-1][c],
                 img[r][c-2],   img[r][c-1],   img[r][c]);
  endfunction

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g
      localparam int W = (gi == 0) ? 4 : (gi == 1) ? 3 : 5;
      localparam int H = (gi == 0) ? 4 : (gi == 1) ? 3 : 4;
      sobel_window_ctrl_if ifc();
      logic [7:0] core_q;

      sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset_s[gi]),
        .start      (start_s[gi]),
        .bus        (ifc),
        .busy       (busy_o[gi]),
        .frame_done (fd_o[gi])
      );

      assign ifc.pix_in     = pix_s[gi];
      assign ifc.pix_valid  = valid_s[gi];
      assign ifc.core_z_out = core_q;
      assign ready_o[gi]    = ifc.pix_ready;
      assign outv_o[gi]     = ifc.out_valid;
      assign outp_o[gi]     = ifc.out_pix;

      always @(posedge clk)
        core_q <= sobel(int'(ifc.z1), int'(ifc.z2), int'(ifc.z3), int'(ifc.z4),
                        int'(ifc.z6), int'(ifc.z7), int'(ifc.z8), int'(ifc.z9));
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (outv_o[d] === 1'b1) begin
        out_cnt[d]++;
        cap_q.push_back(outp_o[d]);
        if (exp_q.size() == 0) begin
          check("out_with_empty_scoreboard", exp_q.size(), 1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_pix", outp_o[d], mon_exp);
          $display("dut%0d out_pix=%0d expected=%0d", d, outp_o[d], mon_exp);
        end
      end
      if (fd_o[d] === 1'b1) begin
        fd_cnt[d]++;
        check("fd_with_out_valid", outv_o[d], 1);
        check("busy_at_fd", busy_o[d], 1);
      end
      if (fd_prev[d]) check("busy_after_fd", busy_o[d], 0);
      fd_prev[d] = (fd_o[d] === 1'b1);
    end
  end

  task automatic send_pix(input int d, input logic [7:0] v, input int gap);
    int   n;
    logic acc;
    if (gap > 0) begin
      valid_s[d] = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    pix_s[d] = v;
    valid_s[d] = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (ready_o[d] === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", n, 0);
  endtask

  task automatic run_frame(input int d, input int w, input int h, input int gapmax, input bit poke);
    int c0;
    bit got;
    c0 = out_cnt[d];
    cap_q.delete();
    start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r >= 2 && c >= 2) exp_q.push_back(sobel_ref(r, c));
        if (poke && r == 1 && c == 1) start_s[d] = 1'b1;
        send_pix(d, 8'(img[r][c]), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        start_s[d] = 1'b0;
      end
    end
    valid_s[d] = 1'b0;
    if (poke) start_s[d] = 1'b1;  // held across both DRAIN cycles
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = (fd_o[d] === 1'b1);
    end
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    check("frame_done_seen", got, 1);
    check("out_count", out_cnt[d] - c0, (w - 2) * (h - 2));
    check("scoreboard_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_frame", busy_o[d], 0);
    $display("dut%0d frame %0dx%0d outputs=%0d", d, w, h, out_cnt[d] - c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int f0;
    for (int d = 0; d < NDUT; d++) begin
      reset_s[d] = 1'b1; start_s[d] = 1'b0; valid_s[d] = 1'b0; pix_s[d] = '0;
      out_cnt[d] = 0; fd_cnt[d] = 0; fd_prev[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) reset_s[d] = 1'b0;

    // reset state
    check("rst_busy", busy_o[0], 0);
    check("rst_ready", ready_o[0], 0);
    check("rst_out_valid", outv_o[0], 0);
    check("rst_frame_done", fd_o[0], 0);
    check("rst_z9", g[0].ifc.z9, 0);
    check("rst_z1", g[0].ifc.z1, 0);

    // 4x4 flat frame: four zero gradients
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = 100;
    run_frame(0, 4, 4, 0, 1'b0);

    // 3x3 step frame: latency and tap check
    for (int r = 0; r < 3; r++) begin
      img[r][0] = 0; img[r][1] = 0; img[r][2] = 255;
    end
    c0 = out_cnt[1];
    start_s[1] = 1'b1;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (r == 2 && c == 2) exp_q.push_back(sobel_ref(r, c));
        send_pix(1, 8'(img[r][c]), 0);
      end
    end
    valid_s[1] = 1'b0;
    @(negedge clk);
    check("lat_edge1_out_valid", outv_o[1], 0);
    @(negedge clk);
    check("lat_edge2_out_valid", outv_o[1], 1);
    check("lat_edge2_frame_done", fd_o[1], 1);
    check("step_out_pix", outp_o[1], 127);
    check("step_z3", g[1].ifc.z3, 255);
    check("step_z6", g[1].ifc.z6, 255);
    check("step_z9", g[1].ifc.z9, 255);
    check("step_z1", g[1].ifc.z1, 0);
    check("step_z2", g[1].ifc.z2, 0);
    check("step_z4", g[1].ifc.z4, 0);
    check("step_z7", g[1].ifc.z7, 0);
    check("step_z8", g[1].ifc.z8, 0);
    repeat (3) @(posedge clk);
    #1;
    check("step_out_count", out_cnt[1] - c0, 1);
    check("step_idle", busy_o[1], 0);

    // 5x4 random frame, gap-free then with valid gaps
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame(2, 5, 4, 0, 1'b0);
    ref_cap = cap_q;
    run_frame(2, 5, 4, 3, 1'b0);
    check("gap_run_len", cap_q.size(), ref_cap.size());
    for (int i = 0; i < ref_cap.size() && i < cap_q.size(); i++)
      check("gap_run_pix", cap_q[i], ref_cap[i]);

    // start pokes during STREAM and DRAIN on a random 4x4 frame
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame(0, 4, 4, 0, 1'b1);

    // reset after 7 accepts, with start and valid also high
    c0 = out_cnt[0];
    f0 = fd_cnt[0];
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    for (int i = 0; i < 7; i++) send_pix(0, 8'(img[i / 4][i % 4]), 0);
    start_s[0] = 1'b1;
    reset_s[0] = 1'b1;
    @(posedge clk);
    #1;
    reset_s[0] = 1'b0;
    start_s[0] = 1'b0;
    valid_s[0] = 1'b0;
    check("midrst_busy", busy_o[0], 0);
    check("midrst_ready", ready_o[0], 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_out", out_cnt[0] - c0, 0);
    check("midrst_no_fd", fd_cnt[0] - f0, 0);
    check("midrst_still_idle", busy_o[0], 0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame(0, 4, 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
